// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: sequencer state encoding, next-PC select codes
// and small address helpers used by the decoder, sequencer and next-PC logic.
package riscv_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } seq_state_t;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_BR    = 2'd1;
    localparam logic [1:0] PC_SEL_JAL   = 2'd2;
    localparam logic [1:0] PC_SEL_JALR  = 2'd3;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // RV32I without the C extension requires every fetch address to be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/riscv_next_pc.sv
// Combinational next-PC selection for the sequencer, plus the word-alignment
// check on the selected target.
module riscv_next_pc
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic        br_taken,
    input  logic [31:0] target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;

    // Sequential address wraps modulo 2^32 by construction of the 32-bit add.
    assign seq_pc = pc + INSTR_BYTES;

    always_comb begin
        next_pc = seq_pc;
        case (pc_sel)
            PC_SEL_PLUS4: next_pc = seq_pc;
            PC_SEL_BR:    next_pc = br_taken ? target : seq_pc;
            PC_SEL_JAL:   next_pc = target;
            PC_SEL_JALR:  next_pc = target;
            default:      next_pc = seq_pc;
        endcase
    end

    assign misaligned = is_misaligned(next_pc);

endmodule

// File: rtl/riscv_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: owns the PC and steps each
// instruction through fetch/decode/execute/mem/writeback.
// Define RISCV_SEQUENCER_PERF_EN to add 64-bit cycle and retired-instruction counters.
module riscv_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_req_out,
    input  logic        imem_valid_in,
    output logic        ir_load_out,
    output logic [31:0] pc_out,
    input  logic        illegal_in,
    input  logic [1:0]  pc_sel_in,
    input  logic        br_taken_in,
    input  logic [31:0] target_in,
    input  logic        dmem_enable_in,
    input  logic        write_enable_rf_in,
    output logic        dmem_req_out,
    input  logic        dmem_valid_in,
    output logic        rf_write_out,
    output logic        retire_out,
    output logic        trap_out,
    output logic [2:0]  state_out
`ifdef RISCV_SEQUENCER_PERF_EN
    ,
    output logic [63:0] cycle_count_out,
    output logic [63:0] instret_out
`endif
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] next_pc;
    logic        next_pc_misaligned;

    riscv_next_pc u_next_pc (
        .pc         (pc),
        .pc_sel     (pc_sel_in),
        .br_taken   (br_taken_in),
        .target     (target_in),
        .next_pc    (next_pc),
        .misaligned (next_pc_misaligned)
    );

    // npc is captured in EXECUTE so branch inputs need only be valid for that one cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= FETCH;
            pc    <= RESET_PC;
            npc   <= RESET_PC;
        end else begin
            state <= state_next;
            if (state == EXECUTE) begin
                npc <= next_pc;
            end
            if (state == WRITEBACK) begin
                pc <= npc;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem_valid_in) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = illegal_in ? TRAP : EXECUTE;
            end
            EXECUTE: begin
                if (next_pc_misaligned) begin
                    state_next = TRAP;
                end else if (dmem_enable_in) begin
                    state_next = MEM;
                end else begin
                    state_next = WRITEBACK;
                end
            end
            MEM: begin
                if (dmem_valid_in) begin
                    state_next = WRITEBACK;
                end
            end
            WRITEBACK: begin
                state_next = FETCH;
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = TRAP;
            end
        endcase
    end

    // Everything is decoded from the registered state except ir_load, which
    // must fire in the same cycle the fetch data arrives.
    always_comb begin
        imem_req_out = (state == FETCH);
        ir_load_out  = (state == FETCH) && imem_valid_in;
        dmem_req_out = (state == MEM);
        rf_write_out = (state == WRITEBACK) && write_enable_rf_in;
        retire_out   = (state == WRITEBACK);
        trap_out     = (state == TRAP);
        state_out    = state;
        pc_out       = pc;
    end

`ifdef RISCV_SEQUENCER_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_count_out <= 64'd0;
            instret_out     <= 64'd0;
        end else begin
            cycle_count_out <= cycle_count_out + 64'd1;
            if (retire_out) begin
                instret_out <= instret_out + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_sequencer.sv
// Self-checking bench for riscv_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle outputs, compared every cycle at negedge.
module tb_riscv_sequencer;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [2:0]  state;
        logic        imem_req;
        logic        ir_load;
        logic        dmem_req;
        logic        rf_write;
        logic        retire;
        logic        trap;
        logic [31:0] pc;
    } exp_t;

    logic        clk_in = 1'b1;
    logic        rst_in;
    logic        imem_req_out;
    logic        imem_valid_in;
    logic        ir_load_out;
    logic [31:0] pc_out;
    logic        illegal_in;
    logic [1:0]  pc_sel_in;
    logic        br_taken_in;
    logic [31:0] target_in;
    logic        dmem_enable_in;
    logic        write_enable_rf_in;
    logic        dmem_req_out;
    logic        dmem_valid_in;
    logic        rf_write_out;
    logic        retire_out;
    logic        trap_out;
    logic [2:0]  state_out;
`ifdef RISCV_SEQUENCER_PERF_EN
    logic [63:0] cycle_count_out;
    logic [63:0] instret_out;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_cur;
    bit          chk_en   = 1'b0;
    logic [31:0] model_pc = RESET_PC;
    bit          trapped  = 1'b0;
    longint      cyc_model = 0;
    longint      ir_model  = 0;
    int          dmem_hi_cnt = 0;
    int          retire_seen = 0;
    int          retire_cycles[$];

    riscv_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .imem_req_out       (imem_req_out),
        .imem_valid_in      (imem_valid_in),
        .ir_load_out        (ir_load_out),
        .pc_out             (pc_out),
        .illegal_in         (illegal_in),
        .pc_sel_in          (pc_sel_in),
        .br_taken_in        (br_taken_in),
        .target_in          (target_in),
        .dmem_enable_in     (dmem_enable_in),
        .write_enable_rf_in (write_enable_rf_in),
        .dmem_req_out       (dmem_req_out),
        .dmem_valid_in      (dmem_valid_in),
        .rf_write_out       (rf_write_out),
        .retire_out         (retire_out),
        .trap_out           (trap_out),
        .state_out          (state_out)
`ifdef RISCV_SEQUENCER_PERF_EN
        ,
        .cycle_count_out    (cycle_count_out),
        .instret_out        (instret_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        cmp("state",    64'(state_out),    64'(exp_cur.state));
        cmp("imem_req", 64'(imem_req_out), 64'(exp_cur.imem_req));
        cmp("ir_load",  64'(ir_load_out),  64'(exp_cur.ir_load));
        cmp("dmem_req", 64'(dmem_req_out), 64'(exp_cur.dmem_req));
        cmp("rf_write", 64'(rf_write_out), 64'(exp_cur.rf_write));
        cmp("retire",   64'(retire_out),   64'(exp_cur.retire));
        cmp("trap",     64'(trap_out),     64'(exp_cur.trap));
        cmp("pc",       64'(pc_out),       64'(exp_cur.pc));
`ifdef RISCV_SEQUENCER_PERF_EN
        cmp("cycle_count", cycle_count_out, 64'(cyc_model));
        cmp("instret",     instret_out,     64'(ir_model));
`endif
    endtask

    // Compare process: outputs sampled mid-cycle, away from the active edge.
    always @(negedge clk_in) begin
        if (chk_en) begin
            checkOutput();
            if (dmem_req_out === 1'b1) dmem_hi_cnt++;
            if (retire_out === 1'b1) begin
                retire_seen++;
                retire_cycles.push_back(int'(cyc_model) + 1);
            end
        end
    end

    function automatic exp_t mkExp(input seq_state_t s);
        exp_t e;
        e = '0;
        e.state = s;
        e.pc    = model_pc;
        return e;
    endfunction

    task automatic randomNoise();
        imem_valid_in      = 1'($urandom_range(0, 1));
        illegal_in         = 1'($urandom_range(0, 1));
        pc_sel_in          = 2'($urandom_range(0, 3));
        br_taken_in        = 1'($urandom_range(0, 1));
        target_in          = $urandom();
        dmem_enable_in     = 1'($urandom_range(0, 1));
        write_enable_rf_in = 1'($urandom_range(0, 1));
        dmem_valid_in      = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input exp_t e, input bit chk);
        exp_cur = e;
        chk_en  = chk;
        @(posedge clk_in);
        if (rst_in) begin
            cyc_model = 0;
            ir_model  = 0;
        end else begin
            cyc_model++;
            if (chk && e.retire) ir_model++;
        end
        #1;
    endtask

    task automatic doReset(input int n);
        exp_t e;
        rst_in = 1'b1;
        randomNoise();
        imem_valid_in = 1'b0;
        applyStimulus(mkExp(FETCH), 1'b0);
        model_pc = RESET_PC;
        trapped  = 1'b0;
        for (int k = 1; k < n; k++) begin
            randomNoise();
            imem_valid_in = 1'b0;
            e = mkExp(FETCH);
            e.imem_req = 1'b1;
            applyStimulus(e, 1'b1);
        end
        rst_in = 1'b0;
    endtask

    // One instruction at the model level: fetch wait, decode, execute, optional
    // memory wait, writeback. Target selection follows the architectural rules.
    task automatic runInstr(input int iw, input logic ill, input logic [1:0] sel,
                            input logic br, input logic [31:0] tgt, input logic den,
                            input logic wen, input int dw);
        exp_t        e;
        logic [31:0] npc;
        for (int k = 0; k <= iw; k++) begin
            randomNoise();
            imem_valid_in = (k == iw);
            e = mkExp(FETCH);
            e.imem_req = 1'b1;
            e.ir_load  = (k == iw);
            applyStimulus(e, 1'b1);
        end
        randomNoise();
        illegal_in = ill;
        applyStimulus(mkExp(DECODE), 1'b1);
        if (ill) begin
            trapped = 1'b1;
            return;
        end
        randomNoise();
        pc_sel_in      = sel;
        br_taken_in    = br;
        target_in      = tgt;
        dmem_enable_in = den;
        applyStimulus(mkExp(EXECUTE), 1'b1);
        if (sel == PC_SEL_PLUS4 || (sel == PC_SEL_BR && !br)) npc = model_pc + 32'd4;
        else                                                  npc = tgt;
        if (npc % 4 != 0) begin
            trapped = 1'b1;
            return;
        end
        if (den) begin
            for (int k = 0; k <= dw; k++) begin
                randomNoise();
                dmem_valid_in = (k == dw);
                e = mkExp(MEM);
                e.dmem_req = 1'b1;
                applyStimulus(e, 1'b1);
            end
        end
        randomNoise();
        write_enable_rf_in = wen;
        e = mkExp(WRITEBACK);
        e.rf_write = wen;
        e.retire   = 1'b1;
        applyStimulus(e, 1'b1);
        model_pc = npc;
    endtask

    task automatic trapHold(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            randomNoise();
            e = mkExp(TRAP);
            e.trap = 1'b1;
            applyStimulus(e, 1'b1);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] tgt;
        rst_in = 1'b1;
        randomNoise();
        doReset(2);
        cmp("reset_pc", 64'(pc_out), 64'h0);

        // addi, addi, add with zero-wait memories
        for (int i = 0; i < 3; i++) runInstr(0, 1'b0, PC_SEL_PLUS4, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        cmp("alu3_pc", 64'(pc_out), 64'd12);
        cmp("alu3_retires", 64'(retire_seen), 64'd3);
        cmp("retire_cyc0", 64'(retire_cycles[0]), 64'd4);
        cmp("retire_cyc1", 64'(retire_cycles[1]), 64'd8);
        cmp("retire_cyc2", 64'(retire_cycles[2]), 64'd12);

        // lw with 3 wait cycles
        dmem_hi_cnt = 0;
        runInstr(0, 1'b0, PC_SEL_PLUS4, 1'b0, 32'h0, 1'b1, 1'b1, 3);
        cmp("lw_dmem_req_cycles", 64'(dmem_hi_cnt), 64'd4);
        cmp("lw_retire_cycle", 64'(retire_cycles[3]), 64'd20);
        cmp("lw_pc", 64'(pc_out), 64'd16);

        // beq taken / not taken
        runInstr(1, 1'b0, PC_SEL_BR, 1'b1, 32'h100, 1'b0, 1'b0, 0);
        cmp("beq_taken_pc", 64'(pc_out), 64'h100);
        doReset(2);
        runInstr(0, 1'b0, PC_SEL_BR, 1'b0, 32'h100, 1'b0, 1'b0, 0);
        cmp("beq_not_taken_pc", 64'(pc_out), 64'h4);

        // reset while a data request is outstanding; valid arrives during and after reset
        randomNoise(); imem_valid_in = 1'b1;
        e = mkExp(FETCH); e.imem_req = 1'b1; e.ir_load = 1'b1;
        applyStimulus(e, 1'b1);
        randomNoise(); illegal_in = 1'b0;
        applyStimulus(mkExp(DECODE), 1'b1);
        randomNoise(); pc_sel_in = PC_SEL_PLUS4; dmem_enable_in = 1'b1;
        applyStimulus(mkExp(EXECUTE), 1'b1);
        randomNoise(); dmem_valid_in = 1'b0;
        e = mkExp(MEM); e.dmem_req = 1'b1;
        applyStimulus(e, 1'b1);
        randomNoise(); rst_in = 1'b1; dmem_valid_in = 1'b1; imem_valid_in = 1'b0;
        applyStimulus(e, 1'b1);
        rst_in = 1'b0;
        model_pc = RESET_PC;
        randomNoise(); imem_valid_in = 1'b0; dmem_valid_in = 1'b1;
        e = mkExp(FETCH); e.imem_req = 1'b1;
        applyStimulus(e, 1'b1);
        cmp("mid_mem_reset_pc", 64'(pc_out), 64'h0);

        // jal to 0x40, then misaligned jalr traps and stays stuck
        runInstr(0, 1'b0, PC_SEL_JAL, 1'b0, 32'h40, 1'b0, 1'b1, 0);
        runInstr(0, 1'b0, PC_SEL_JALR, 1'b0, 32'h102, 1'b0, 1'b1, 0);
        cmp("jalr_trapped_model", 64'(trapped), 64'd1);
        trapHold(20);
        cmp("trap_pc_frozen", 64'(pc_out), 64'h40);
        cmp("trap_sticky", 64'(trap_out), 64'd1);

        // PC wraps modulo 2^32
        doReset(2);
        runInstr(0, 1'b0, PC_SEL_JAL, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 0);
        runInstr(0, 1'b0, PC_SEL_PLUS4, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        cmp("pc_wrap", 64'(pc_out), 64'h0);

`ifdef RISCV_SEQUENCER_PERF_EN
        doReset(2);
        for (int i = 0; i < 10; i++) runInstr(0, 1'b0, PC_SEL_PLUS4, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        cmp("perf_instret", instret_out, 64'd10);
        cmp("perf_cycles", cycle_count_out, 64'd40);
`endif

        // randomized instruction stream
        doReset(2);
        for (int i = 0; i < 250; i++) begin
            if (trapped) begin
                trapHold($urandom_range(1, 5));
                doReset($urandom_range(1, 3));
            end
            tgt = $urandom();
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            runInstr($urandom_range(0, 2),
                     1'($urandom_range(0, 15) == 0),
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     tgt,
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 3));
        end

        chk_en = 1'b0;
        @(posedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_sequencer.md
# riscv_sequencer

Multi-cycle control sequencer for the single-issue RV32I core. It owns the program counter and steps each instruction through fetch, decode, execute, memory and writeback. It drives the instruction- and data-memory request handshakes and gates register-file and PC writes. It consumes the control fields produced by `riscv_decode`, plus branch/target results from the ALU and branch unit.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk_in`  in  1  core clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `imem_req_out`  out  1  instruction fetch request, address = `pc_out`.
- `imem_valid_in`  in  1  fetch data valid; may assert in the same cycle as the request.
- `ir_load_out`  out  1  one-cycle pulse: latch instruction word into IR.
- `pc_out`  out  32  current PC.
- `illegal_in`  in  1  decoder flags the IR as unsupported.
- `pc_sel_in`  in  2  next-PC select from decoder: 0 = +4, 1 = branch, 2 = jal, 3 = jalr.
- `br_taken_in`  in  1  branch comparator result, valid in EXECUTE.
- `target_in`  in  32  branch/jal/jalr target, valid in EXECUTE.
- `dmem_enable_in`  in  1  instruction accesses data memory.
- `write_enable_rf_in`  in  1  instruction writes rd.
- `dmem_req_out`  out  1  data memory request.
- `dmem_valid_in`  in  1  data access complete; may assert in the same cycle as the request.
- `rf_write_out`  out  1  register-file write strobe.
- `retire_out`  out  1  one-cycle pulse per completed instruction.
- `trap_out`  out  1  sticky halt indicator.
- `state_out`  out  3  current FSM state, for debug.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH
  - `imem_req_out`=1, held until `imem_valid_in`.
  - On valid: pulse `ir_load_out`, go to DECODE.
- DECODE: one cycle. If `illegal_in`, go to TRAP; otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - Latch the next PC into an internal `npc` register:
    - `pc_sel_in`=1 and `br_taken_in`: `target_in`.
    - `pc_sel_in`=1 and not `br_taken_in`: `pc_out+4`.
    - `pc_sel_in`=2 or 3: `target_in`.
    - `pc_sel_in`=0: `pc_out+4`.
  - If `npc[1:0]`≠0, go to TRAP (misaligned target).
  - Otherwise go to MEM if `dmem_enable_in`, else to WRITEBACK.
- MEM
  - `dmem_req_out`=1, held until `dmem_valid_in`, then go to WRITEBACK.
  - `dmem_req_out` must never drop before `dmem_valid_in`.
- WRITEBACK
  - `rf_write_out`=`write_enable_rf_in`.
  - `pc_out`←`npc`.
  - `retire_out`=1.
  - Go to FETCH.
- TRAP
  - `trap_out`=1, all requests and strobes 0, `pc_out` frozen.
  - Exits only via reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- `rf_write_out` is forced 0 when the decoded rd is x0. The decoder guarantees this by clearing `write_enable_rf_in`.

## Timing
- Reset values: state FETCH, `pc_out`=`RESET_PC`, `trap_out`=0, `ir_load_out`/`rf_write_out`/`retire_out`/`dmem_req_out`=0.
- `imem_req_out`=1 in the first cycle after reset deassertion.
- Minimum latency with zero-wait memories:
  - ALU/branch/jump instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load/store: 5 cycles.
- Each cycle of memory wait adds exactly one cycle.
- All outputs are Moore, decoded from registered state, except `ir_load_out`. It is combinational from FETCH && `imem_valid_in`.
- Reset mid-operation, e.g. in MEM with a request outstanding:
  - Returns to FETCH at the next edge and drops `dmem_req_out`.
  - No retire or RF write occurs.
  - A late `dmem_valid_in` is ignored.
- A `dmem_valid_in` or `imem_valid_in` seen outside its own state is ignored.

## Configuration
- `RISCV_SEQUENCER_PERF_EN` defined: adds two ports.
  - `cycle_count_out[63:0]`: increments every non-reset cycle, including TRAP.
  - `instret_out[63:0]`: increments on `retire_out`.
  - Both reset to 0 and wrap at 2^64.
- Undefined: neither port nor counter exists.

## Structure
- Shared package `riscv_pkg` holds:
  - the state enum `seq_state_t` (3-bit);
  - `pc_sel` encodings `PC_SEL_PLUS4`/`PC_SEL_BR`/`PC_SEL_JAL`/`PC_SEL_JALR`.
- The decoder already imports the `pc_sel` encodings from this package.
- One natural sub-module: `riscv_next_pc`, the combinational next-PC select plus misalignment check. Everything else is flat.

## Test plan
- Zero-wait memories, program `addi`,`addi`,`add` from `RESET_PC`=0 -> `retire_out` at cycles 4, 8, 12; `pc_out` goes 0→4→8→12.
- `lw` with `dmem_valid_in` delayed 3 cycles -> `dmem_req_out` high 4 cycles, retire on cycle 8, `rf_write_out`=1 only in WRITEBACK.
- `beq` with `br_taken_in`=1 and `target_in`=0x100 -> `pc_out`=0x100. Same instruction with `br_taken_in`=0 -> `pc_out`=0x4.
- `jalr` with `target_in`=0x102 -> TRAP, `trap_out`=1, no retire, `pc_out` unchanged, then stays stuck for 20 cycles.
- Assert `rst_in` in MEM while `dmem_req_out`=1, pulse `dmem_valid_in` during reset -> `pc_out`=`RESET_PC`, no retire, FETCH request next cycle.
- With `RISCV_SEQUENCER_PERF_EN`, run 10 zero-wait ALU ops -> `instret_out`=10, `cycle_count_out`=40.
